seven_segment_scanner: RTL and testbench

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

---
 rtl/seven_segment_scanner.sv | 128 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner with PWM brightness.
// Frame data is double-buffered and swapped only on frame boundaries.
//
// Ports:
//   clk, rst    : clock, async active-high reset
//   load_valid  : new frame offered
//   load_ready  : shadow buffer free
//   load_data   : hex nibbles, digit k = [4k+3:4k]
//   load_blank  : per-digit blank mask
//   brightness  : lit phases per slot (0..15)
//   digit_en    : one-hot digit select, or zero
//   display     : segments, bit6 = top .. bit0 = middle
//   digit_idx   : digit currently scanned
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PHASE_LEN  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_blank,
  input  logic [3:0]                    brightness,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [6:0]                    display,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

  logic [PW-1:0]           r_phase_cnt;
  logic [3:0]              r_phase;
  logic [IW-1:0]           r_digit;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_blank;
  logic [4*NUM_DIGITS-1:0] r_active_data;
  logic [NUM_DIGITS-1:0]   r_active_blank;
  logic [NUM_DIGITS-1:0]   r_digit_en;
  logic [6:0]              r_display;
  logic [IW-1:0]           r_digit_idx;

  logic                    w_pc_wrap;
  logic                    w_ph_wrap;
  logic                    w_boundary;
  logic                    w_accept;
  logic [3:0]              w_nibble;
  logic [6:0]              w_seg;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_pc_wrap  = (r_phase_cnt == PW'(PHASE_LEN - 1));
  assign w_ph_wrap  = w_pc_wrap && (r_phase == 4'hF);
  assign w_boundary = w_ph_wrap && (r_digit == IW'(NUM_DIGITS - 1));
  assign w_accept   = load_valid && !r_pending;
  assign load_ready = !r_pending;

  assign w_nibble = r_active_data[{r_digit, 2'b00} +: 4];
  assign w_onehot = NUM_DIGITS'(1) << r_digit;
  assign w_lit    = (r_phase < brightness) && !r_active_blank[r_digit];

  always_comb begin
    w_seg = 7'h00;
    case (w_nibble)
      4'h0: w_seg = 7'h7E;
      4'h1: w_seg = 7'h30;
      4'h2: w_seg = 7'h6D;
      4'h3: w_seg = 7'h79;
      4'h4: w_seg = 7'h33;
      4'h5: w_seg = 7'h5B;
      4'h6: w_seg = 7'h5F;
      4'h7: w_seg = 7'h70;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h7B;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h1F;
      4'hC: w_seg = 7'h4E;
      4'hD: w_seg = 7'h3D;
      4'hE: w_seg = 7'h4F;
      4'hF: w_seg = 7'h47;
      default: w_seg = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase_cnt    <= '0;
      r_phase        <= '0;
      r_digit        <= '0;
      r_pending      <= 1'b0;
      r_shadow_data  <= '0;
      r_shadow_blank <= '0;
      r_active_data  <= '0;
      r_active_blank <= '1;
      r_digit_en     <= '0;
      r_display      <= '0;
      r_digit_idx    <= '0;
    end else begin
      r_phase_cnt <= w_pc_wrap ? '0 : r_phase_cnt + PW'(1);
      if (w_pc_wrap)
        r_phase <= r_phase + 4'd1;
      if (w_ph_wrap)
        r_digit <= w_boundary ? '0 : r_digit + IW'(1);

      // accept and swap are exclusive: accept needs pending clear
      if (w_accept) begin
        r_shadow_data  <= load_data;
        r_shadow_blank <= load_blank;
        r_pending      <= 1'b1;
      end else if (w_boundary && r_pending) begin
        r_active_data  <= r_shadow_data;
        r_active_blank <= r_shadow_blank;
        r_pending      <= 1'b0;
      end

      r_digit_en  <= w_lit ? w_onehot : '0;
      r_display   <= w_lit ? w_seg : 7'h00;
      r_digit_idx <= r_digit;
    end
  end

  assign digit_en  = r_digit_en;
  assign display   = r_display;
  assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner.
// Frame-position model plus literal scenario checks.
module tb_seven_segment_scanner;

  localparam int FRAME = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  load_blank = '0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  digit_en;
  logic [6:0]  display;
  logic [1:0]  digit_idx;

  seven_segment_scanner #(
    .NUM_DIGITS(4),
    .PHASE_LEN (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_blank(load_blank),
    .brightness(brightness),
    .digit_en  (digit_en),
    .display   (display),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n;
  logic [3:0]  m_data [4];
  logic [3:0]  m_blank;
  logic [15:0] sh_data;
  logic [3:0]  sh_blank;
  logic        m_pend;
  logic [6:0]  seg_tab [16];
  int          cnt_on [4];
  logic [6:0]  disp_seen [4];
  logic        last_acc;
  int          acc_pos;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", nm, act, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 4; k++) m_data[k] = 4'h0;
    m_blank  = 4'hF;
    m_pend   = 1'b0;
    last_acc = 1'b0;
    sh_data  = '0;
    sh_blank = '0;
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      cnt_on[k]    = 0;
      disp_seen[k] = 7'h00;
    end
  endtask

  // One clock: predict outputs from the frame position, then compare.
  task automatic step();
    int pos, d, ph;
    logic lit, acc, bnd;
    logic [3:0]  e_en;
    logic [6:0]  e_disp;
    logic [15:0] in_d;
    logic [3:0]  in_b;
    pos    = n % FRAME;
    d      = pos / 32;
    ph     = (pos % 32) / 2;
    lit    = (ph < int'(brightness)) && !m_blank[d];
    e_en   = lit ? (4'b0001 << d) : 4'b0000;
    e_disp = lit ? seg_tab[m_data[d]] : 7'h00;
    acc    = load_valid && !m_pend;
    bnd    = (pos == FRAME - 1);
    in_d   = load_data;
    in_b   = load_blank;
    @(posedge clk);
    #1;
    if (acc) begin
      sh_data  = in_d;
      sh_blank = in_b;
      m_pend   = 1'b1;
      acc_pos  = pos;
    end else if (bnd && m_pend) begin
      for (int k = 0; k < 4; k++) m_data[k] = sh_data[4*k +: 4];
      m_blank = sh_blank;
      m_pend  = 1'b0;
    end
    last_acc = acc;
    n++;
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("display", 32'(display), 32'(e_disp));
    chk("digit_idx", 32'(digit_idx), 32'(d));
    chk("load_ready", 32'(load_ready), 32'(!m_pend));
    for (int k = 0; k < 4; k++)
      if (digit_en[k]) begin
        cnt_on[k]++;
        disp_seen[k] = display;
      end
  endtask

  task automatic to_frame_start();
    while (n % FRAME != 0) step();
  endtask

  task automatic run_frame();
    clear_stats();
    repeat (FRAME) step();
  endtask

  task automatic hold_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_en", 32'(digit_en), 0);
      chk("rst_disp", 32'(display), 0);
      chk("rst_ready", 32'(load_ready), 1);
      chk("rst_idx", 32'(digit_idx), 0);
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    acc_pos = -1;
    model_reset();
    clear_stats();

    // reset with a load offered: it must be ignored
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    hold_reset();

    // three dark frames, no load
    brightness = 4'd15;
    for (int f = 0; f < 3; f++) begin
      run_frame();
      chk("dark_frame", 32'(cnt_on[0] + cnt_on[1] + cnt_on[2] + cnt_on[3]), 0);
    end

    // mid-frame load of 3A50
    while (n % FRAME != 50) step();
    load_valid = 1'b1;
    load_data  = 16'h3A50;
    load_blank = 4'b0000;
    step();
    load_valid = 1'b0;
    chk("ready_low_after_load", 32'(load_ready), 0);
    to_frame_start();
    run_frame();
    chk("d0_seg", 32'(disp_seen[0]), 32'h7E);
    chk("d1_seg", 32'(disp_seen[1]), 32'h5B);
    chk("d2_seg", 32'(disp_seen[2]), 32'h77);
    chk("d3_seg", 32'(disp_seen[3]), 32'h79);
    for (int k = 0; k < 4; k++) chk("on_b15", 32'(cnt_on[k]), 30);

    // brightness sweep
    brightness = 4'd0;
    run_frame();
    for (int k = 0; k < 4; k++) chk("on_b0", 32'(cnt_on[k]), 0);
    brightness = 4'd1;
    run_frame();
    for (int k = 0; k < 4; k++) chk("on_b1", 32'(cnt_on[k]), 2);
    brightness = 4'd8;
    run_frame();
    for (int k = 0; k < 4; k++) chk("on_b8", 32'(cnt_on[k]), 16);

    // per-digit blank
    brightness = 4'd15;
    while (n % FRAME != 20) step();
    load_valid = 1'b1;
    load_blank = 4'b0101;
    step();
    load_valid = 1'b0;
    load_blank = 4'b0000;
    to_frame_start();
    run_frame();
    chk("blank_d0", 32'(cnt_on[0]), 0);
    chk("blank_d1", 32'(cnt_on[1]), 30);
    chk("blank_d2", 32'(cnt_on[2]), 0);
    chk("blank_d3", 32'(cnt_on[3]), 30);

    // second load stalls while pending
    while (n % FRAME != 70) step();
    load_valid = 1'b1;
    load_data  = 16'h1111;
    step();
    load_data = 16'h2222;
    acc_pos   = -1;
    begin
      int i;
      i = 0;
      step();
      while (!last_acc && i < 300) begin
        step();
        i++;
      end
    end
    load_valid = 1'b0;
    chk("stall_accepted", 32'(last_acc), 1);
    chk("stall_accept_pos", 32'(acc_pos), 0);
    clear_stats();
    to_frame_start();
    chk("first_load_shown", 32'(disp_seen[0]), 32'h30);
    run_frame();
    chk("second_load_shown", 32'(disp_seen[0]), 32'h6D);

    // load on the exact boundary cycle
    while (n % FRAME != FRAME - 1) step();
    load_valid = 1'b1;
    load_data  = 16'h4444;
    step();
    load_valid = 1'b0;
    chk("bnd_accept_pos", 32'(acc_pos), FRAME - 1);
    run_frame();
    chk("bnd_not_yet", 32'(disp_seen[0]), 32'h6D);
    run_frame();
    chk("bnd_shown", 32'(disp_seen[0]), 32'h33);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) brightness = 4'($urandom);
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = 16'($urandom);
      load_blank = 4'($urandom);
      step();
    end
    load_valid = 1'b0;
    load_blank = 4'b0000;
    brightness = 4'd15;

    // async reset mid-slot with a live frame
    load_valid = 1'b1;
    load_data  = 16'h8888;
    while (m_pend || n % FRAME != 0) begin
      step();
      if (n > 100000) break;
    end
    load_valid = 1'b0;
    repeat (45) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_en", 32'(digit_en), 0);
    chk("async_disp", 32'(display), 0);
    chk("async_ready", 32'(load_ready), 1);
    hold_reset();
    run_frame();
    chk("post_rst_dark", 32'(cnt_on[0] + cnt_on[1] + cnt_on[2] + cnt_on[3]), 0);
    while (n % FRAME != 10) step();
    load_valid = 1'b1;
    load_data  = 16'hFFFF;
    step();
    load_valid = 1'b0;
    to_frame_start();
    run_frame();
    chk("post_rst_load_seg", 32'(disp_seen[0]), 32'h47);
    chk("post_rst_load_on", 32'(cnt_on[0]), 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
